// File: rtl/fir_sink_pkg.sv
// Shared constants for the FIR-to-DAC sink: default widths, FIFO depth and the
// rounding/saturation limits of the 14-bit DAC path.
package fir_sink_pkg;

  localparam int unsigned IN_W  = 40;
  localparam int unsigned OUT_W = 14;
  localparam int unsigned SHIFT = 19;
  localparam int unsigned DEPTH = 4;

  localparam int OUT_MAX = 8191;
  localparam int OUT_MIN = -8192;

  localparam longint unsigned ROUND_K = 64'd1 << (SHIFT - 1);

endpackage

// File: rtl/fir_axis_dac_sink_if.sv
// AXI4-Stream data channel between the FIR compiler master and the DAC sink.
interface fir_axis_dac_sink_if #(
  parameter int unsigned IN_W = fir_sink_pkg::IN_W
);

  logic [IN_W-1:0] tdata;
  logic            tvalid;
  logic            tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/fir_axis_dac_sink_sample_fifo.sv
// Small synchronous sample FIFO with a registered read port; rd_data holds the
// last popped sample until the next pop.
module sample_fifo #(
  parameter int unsigned Depth = fir_sink_pkg::DEPTH,
  parameter int unsigned Width = fir_sink_pkg::OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [Width-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [Width-1:0]         rd_data,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic [Width-1:0] rd_data_q;
  logic             do_wr, do_rd;

  assign full  = (count_q == DepthC);
  assign empty = (count_q == '0);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  assign count   = count_q;
  assign rd_data = rd_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem[rd_ptr_q];
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/fir_axis_dac_sink.sv
// AXI4-Stream sink for the FIR compiler output: round, shift and saturate to DAC
// width, buffer in a small FIFO and release one sample per dac_en strobe.
module fir_axis_dac_sink #(
  parameter int unsigned IN_W  = fir_sink_pkg::IN_W,
  parameter int unsigned OUT_W = fir_sink_pkg::OUT_W,
  parameter int unsigned SHIFT = fir_sink_pkg::SHIFT,
  parameter int unsigned DEPTH = fir_sink_pkg::DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  fir_axis_dac_sink_if.slave s_axis,
  input  logic               dac_en,
  output logic [OUT_W-1:0]   dac_data,
  output logic               dac_valid,
  output logic               underflow,
  output logic [15:0]        sat_cnt
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned RW   = IN_W + 1;

  localparam logic signed [RW-1:0] RoundK = {{(RW - 1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [RW-1:0] SatMax = {{(RW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [RW-1:0] SatMin = {{(RW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic [CntW:0]        DepthOcc = (CntW + 1)'(DEPTH);

  logic signed [RW-1:0] tdata_ext, rnd, shifted;
  logic signed [RW-1:0] s1_q;
  logic                 s1_valid_q;
  logic [OUT_W-1:0]     s2_q;
  logic                 s2_valid_q;
  logic [OUT_W-1:0]     q_sat;
  logic                 sat_hi, sat_lo;
  logic [15:0]          sat_cnt_q;
  logic                 dac_valid_q, underflow_q;

  logic                 xfer;
  logic [CntW:0]        occ;
  logic                 fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [CntW-1:0]      fifo_count;

  // Occupancy counts in-flight pipeline slots so accepted samples always fit.
  assign occ = {1'b0, fifo_count} + {{CntW{1'b0}}, s1_valid_q} + {{CntW{1'b0}}, s2_valid_q};
  assign s_axis.tready = rst & (occ < DepthOcc);
  assign xfer = s_axis.tvalid & s_axis.tready;

  assign tdata_ext = {s_axis.tdata[IN_W-1], s_axis.tdata};
  assign rnd       = tdata_ext + RoundK;
  assign shifted   = s1_q >>> SHIFT;
  assign sat_hi    = (shifted > SatMax);
  assign sat_lo    = (shifted < SatMin);

  always_comb begin
    q_sat = shifted[OUT_W-1:0];
    if (sat_hi)      q_sat = {1'b0, {(OUT_W - 1){1'b1}}};
    else if (sat_lo) q_sat = {1'b1, {(OUT_W - 1){1'b0}}};
  end

  assign fifo_wr = s2_valid_q;
  assign fifo_rd = dac_en & ~fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      s2_q        <= '0;
      s2_valid_q  <= 1'b0;
      sat_cnt_q   <= '0;
      dac_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      s1_valid_q <= xfer;
      if (xfer) s1_q <= rnd;
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_q <= q_sat;
      if (s1_valid_q && (sat_hi || sat_lo) && (sat_cnt_q != 16'hFFFF)) begin
        sat_cnt_q <= sat_cnt_q + 16'd1;
      end
      dac_valid_q <= dac_en & ~fifo_empty;
      underflow_q <= dac_en & fifo_empty;
    end
  end

  sample_fifo #(
    .Depth (DEPTH),
    .Width (OUT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (s2_q),
    .rd_en   (fifo_rd),
    .rd_data (dac_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign dac_valid = dac_valid_q;
  assign underflow = underflow_q;
  assign sat_cnt   = sat_cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(fifo_wr && fifo_full));

endmodule

// File: tb/tb_fir_axis_dac_sink.sv
// Randomized and directed bench for fir_axis_dac_sink against a queue-based
// arithmetic model of rounding, saturation and in-order delivery.
module tb_fir_axis_dac_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dac_en = 1'b0;
  logic [13:0] dac_data;
  logic        dac_valid;
  logic        underflow;
  logic [15:0] sat_cnt;

  fir_axis_dac_sink_if #(.IN_W(40)) s_axis ();

  fir_axis_dac_sink dut (
    .clk       (clk),
    .rst       (rst),
    .s_axis    (s_axis),
    .dac_en    (dac_en),
    .dac_data  (dac_data),
    .dac_valid (dac_valid),
    .underflow (underflow),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  int     pass_cnt = 0;
  int     total_cnt = 0;
  int     xfer_cnt = 0;
  int     exp_sat = 0;
  logic   last_xfer = 1'b0;
  longint exp_q[$];
  longint got_q[$];

  // Round half up then floor-divide by 2^19, clamp to the signed 14-bit range.
  function automatic longint model(input longint x, output bit sat);
    longint num, q;
    num = x + 64'sd262144;
    q = num / 64'sd524288;
    if ((num % 64'sd524288) < 0) q = q - 1;
    sat = 1'b0;
    if (q > 8191) begin
      q = 8191;
      sat = 1'b1;
    end else if (q < -8192) begin
      q = -8192;
      sat = 1'b1;
    end
    return q;
  endfunction

  task automatic step(input logic en);
    logic   x;
    bit     sat;
    longint e;
    dac_en = en;
    x = s_axis.tvalid & s_axis.tready;
    @(posedge clk);
    #1;
    last_xfer = x;
    if (x) begin
      xfer_cnt++;
      e = model(longint'($signed(s_axis.tdata)), sat);
      exp_q.push_back(e);
      if (sat && exp_sat < 65535) exp_sat++;
    end
    if (dac_valid) got_q.push_back(longint'($signed(dac_data)));
  endtask

  task automatic send(input longint x, input logic en);
    s_axis.tdata = x[39:0];
    s_axis.tvalid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step(en);
      if (last_xfer) break;
    end
    s_axis.tvalid = 1'b0;
  endtask

  task automatic drain(input int budget);
    s_axis.tvalid = 1'b0;
    for (int i = 0; i < budget && got_q.size() < exp_q.size(); i++) step(1'b1);
    step(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_axis.tvalid = 1'b1;
    s_axis.tdata = 40'd5 << 19;
    dac_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total_cnt++;
    if (s_axis.tready !== 1'b0) $display("FAIL reset_tready: got %0b expected 0", s_axis.tready);
    else pass_cnt++;
    total_cnt++;
    if (dac_data !== 14'd0) $display("FAIL reset_dac_data: got %0d expected 0", dac_data);
    else pass_cnt++;
    total_cnt++;
    if (sat_cnt !== 16'd0) $display("FAIL reset_sat_cnt: got %0d expected 0", sat_cnt);
    else pass_cnt++;
    total_cnt++;
    if (dac_valid !== 1'b0 || underflow !== 1'b0)
      $display("FAIL reset_flags: got valid=%0b uf=%0b expected 0 0", dac_valid, underflow);
    else pass_cnt++;
    s_axis.tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (s_axis.tready !== 1'b1) $display("FAIL release_tready: got %0b expected 1", s_axis.tready);
    else pass_cnt++;
  endtask

  task automatic test_rounding();
    longint ref_v[4];
    ref_v = '{1, 1, 0, -1};
    exp_q.delete();
    got_q.delete();
    send(64'sd524288, 1'b1);
    send(64'sd262144, 1'b1);
    send(64'sd262143, 1'b1);
    send(-64'sd262145, 1'b1);
    drain(40);
    total_cnt++;
    if (got_q.size() != 4) $display("FAIL round_count: got %0d expected 4", got_q.size());
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] != ref_v[i])
        $display("FAIL round_value[%0d]: got %0d expected %0d", i,
                 (i < got_q.size()) ? got_q[i] : 64'sd99999, ref_v[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (sat_cnt !== 16'd0) $display("FAIL round_sat_cnt: got %0d expected 0", sat_cnt);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    exp_q.delete();
    got_q.delete();
    send(64'sd8589934591, 1'b0);
    send(-64'sd8589934592, 1'b0);
    drain(40);
    total_cnt++;
    if (got_q.size() != 2 || got_q[0] != 8191 || got_q[1] != -8192)
      $display("FAIL sat_values: got n=%0d first=%0d second=%0d expected 8191 -8192",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 0,
               (got_q.size() > 1) ? got_q[1] : 0);
    else pass_cnt++;
    total_cnt++;
    if (sat_cnt !== 16'd2) $display("FAIL sat_cnt_two: got %0d expected 2", sat_cnt);
    else pass_cnt++;

    force dut.sat_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.sat_cnt_q;
    exp_sat = 65535;
    @(posedge clk); #1;
    exp_q.delete();
    got_q.delete();
    send(64'sd8589934591, 1'b0);
    drain(40);
    total_cnt++;
    if (sat_cnt !== 16'hFFFF) $display("FAIL sat_cnt_sticky: got %0h expected ffff", sat_cnt);
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() != 1 || got_q[0] != 8191)
      $display("FAIL sat_after_sticky: got n=%0d v=%0d expected 8191", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 0);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    longint v;
    exp_q.delete();
    got_q.delete();
    xfer_cnt = 0;
    s_axis.tvalid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      v = longint'(xfer_cnt + 1) << 19;
      s_axis.tdata = v[39:0];
      step(1'b0);
    end
    total_cnt++;
    if (xfer_cnt != 4) $display("FAIL bp_accept_count: got %0d expected 4", xfer_cnt);
    else pass_cnt++;
    total_cnt++;
    if (s_axis.tready !== 1'b0) $display("FAIL bp_tready_low: got %0b expected 0", s_axis.tready);
    else pass_cnt++;
    step(1'b1);
    for (int i = 0; i < 10; i++) begin
      v = longint'(xfer_cnt + 1) << 19;
      s_axis.tdata = v[39:0];
      step(1'b0);
    end
    total_cnt++;
    if (xfer_cnt != 5) $display("FAIL bp_one_more: got %0d expected 5", xfer_cnt);
    else pass_cnt++;
    s_axis.tvalid = 1'b0;
    drain(40);
    total_cnt++;
    if (got_q.size() != 5) $display("FAIL bp_out_count: got %0d expected 5", got_q.size());
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] != longint'(i + 1))
        $display("FAIL bp_order[%0d]: got %0d expected %0d", i,
                 (i < got_q.size()) ? got_q[i] : 64'sd99999, i + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_underflow();
    logic [13:0] d0;
    exp_q.delete();
    got_q.delete();
    d0 = dac_data;
    step(1'b1);
    total_cnt++;
    if (underflow !== 1'b1 || dac_valid !== 1'b0 || dac_data !== d0)
      $display("FAIL uf_pulse: got uf=%0b valid=%0b data=%0d expected 1 0 %0d",
               underflow, dac_valid, dac_data, d0);
    else pass_cnt++;
    step(1'b0);
    total_cnt++;
    if (underflow !== 1'b0) $display("FAIL uf_one_cycle: got %0b expected 0", underflow);
    else pass_cnt++;
    send(64'sd3 << 19, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0);
    step(1'b1);
    total_cnt++;
    if (dac_valid !== 1'b1 || $signed(dac_data) != 3)
      $display("FAIL uf_recover: got valid=%0b data=%0d expected 1 3", dac_valid,
               $signed(dac_data));
    else pass_cnt++;
    step(1'b0);
    total_cnt++;
    if (dac_valid !== 1'b0) $display("FAIL valid_one_cycle: got %0b expected 0", dac_valid);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    exp_q.delete();
    got_q.delete();
    send(64'sd10 << 19, 1'b0);
    send(64'sd11 << 19, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0);
    total_cnt++;
    if (dut.u_fifo.count !== 3'd2) $display("FAIL sim_pre_count: got %0d expected 2", dut.u_fifo.count);
    else pass_cnt++;
    send(64'sd12 << 19, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (dut.fifo_wr) break;
      step(1'b0);
    end
    step(1'b1);
    total_cnt++;
    if (dut.u_fifo.count !== 3'd2 || dac_valid !== 1'b1 || $signed(dac_data) != 10)
      $display("FAIL sim_wr_pop: got count=%0d valid=%0b data=%0d expected 2 1 10",
               dut.u_fifo.count, dac_valid, $signed(dac_data));
    else pass_cnt++;
    drain(40);
    total_cnt++;
    if (got_q.size() != 3) $display("FAIL sim_out_count: got %0d expected 3", got_q.size());
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] != longint'(10 + i))
        $display("FAIL sim_order[%0d]: got %0d expected %0d", i,
                 (i < got_q.size()) ? got_q[i] : 64'sd99999, 10 + i);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midstream();
    exp_q.delete();
    got_q.delete();
    send(64'sd20 << 19, 1'b0);
    send(64'sd21 << 19, 1'b0);
    send(64'sd22 << 19, 1'b0);
    step(1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (s_axis.tready !== 1'b0 || dac_data !== 14'd0 || sat_cnt !== 16'd0)
      $display("FAIL mid_reset_state: got tready=%0b data=%0d sat=%0d expected 0 0 0",
               s_axis.tready, dac_data, sat_cnt);
    else pass_cnt++;
    rst = 1'b1;
    exp_q.delete();
    got_q.delete();
    exp_sat = 0;
    @(posedge clk); #1;
    total_cnt++;
    if (dut.u_fifo.count !== 3'd0) $display("FAIL mid_reset_count: got %0d expected 0", dut.u_fifo.count);
    else pass_cnt++;
    send(64'sd23 << 19, 1'b0);
    drain(40);
    total_cnt++;
    if (got_q.size() != 1 || got_q[0] != 23)
      $display("FAIL mid_reset_first: got n=%0d v=%0d expected 1 sample of 23", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 0);
    else pass_cnt++;
    step(1'b1);
    total_cnt++;
    if (underflow !== 1'b1) $display("FAIL mid_reset_empty: got uf=%0b expected 1", underflow);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic              en;
    logic [63:0]       r64;
    logic signed [39:0] t40;
    longint            v;
    exp_q.delete();
    got_q.delete();
    last_xfer = 1'b0;
    s_axis.tvalid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!s_axis.tvalid || last_xfer) begin
        case ($urandom % 4)
          0: v = longint'($urandom_range(0, 16777215)) - 64'sd8388608;
          1: begin
            r64 = {$urandom, $urandom};
            t40 = r64[39:0];
            v = longint'(t40);
          end
          2: v = ((($urandom % 2) != 0) ? 64'sd4294443008 : -64'sd4294967296) +
                 (longint'($urandom_range(0, 16)) - 64'sd8) * 64'sd131072;
          default: v = (longint'($urandom_range(0, 64)) - 64'sd32) * 64'sd262144;
        endcase
        s_axis.tdata = v[39:0];
        s_axis.tvalid = (($urandom % 3) != 0);
      end
      en = (($urandom % 2) != 0);
      step(en);
      total_cnt++;
      if (((dac_valid ^ underflow) !== en) || ((dac_valid & underflow) !== 1'b0))
        $display("FAIL rnd_strobe[%0d]: got valid=%0b uf=%0b expected exactly one iff en=%0b",
                 c, dac_valid, underflow, en);
      else pass_cnt++;
    end
    drain(80);
    total_cnt++;
    if (got_q.size() != exp_q.size())
      $display("FAIL rnd_count: got %0d expected %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] != exp_q[i])
        $display("FAIL rnd_value[%0d]: got %0d expected %0d", i,
                 (i < got_q.size()) ? got_q[i] : 64'sd99999, exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (int'(sat_cnt) != exp_sat) $display("FAIL rnd_sat_cnt: got %0d expected %0d", sat_cnt, exp_sat);
    else pass_cnt++;
  endtask

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata = '0;
    test_reset();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_underflow();
    test_simultaneous();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
